// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between write-back and debug; write-back wins,
// starved debug requests force a one-cycle pipeline stall.
module rf_write_arbiter #(
    parameter int NB_DATA      = 16,
    parameter int NB_REGISTERS = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NB_DATA-1:0]      i_wb_w_data,
    input  logic [NB_REGISTERS-1:0] i_wb_reg_num,
    input  logic                    i_wb_reg_write,
    input  logic                    i_dbg_valid,
    input  logic [NB_REGISTERS-1:0] i_dbg_reg_num,
    input  logic [NB_DATA-1:0]      i_dbg_data,
    output logic                    o_dbg_ready,
    output logic                    o_wb_stall,
    output logic                    o_rf_we,
    output logic [NB_REGISTERS-1:0] o_rf_addr,
    output logic [NB_DATA-1:0]      o_rf_data,
    output logic                    o_rf_src
);
    typedef enum logic {IDLE, STALL} state_t;
    state_t     state;
    logic [7:0] wait_cnt;
    logic       wb_acc, dbg_xfer, blocked, starve;
    assign o_dbg_ready = !i_reset && (state == STALL || !i_wb_reg_write);
    assign wb_acc      = i_wb_reg_write && state == IDLE;
    assign dbg_xfer    = i_dbg_valid && o_dbg_ready;
    assign blocked     = i_dbg_valid && !o_dbg_ready;
    assign starve      = blocked && wait_cnt == 8'(STARVE_LIMIT - 1);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            o_wb_stall <= 1'b0;
            o_rf_we    <= 1'b0;
            o_rf_addr  <= '0;
            o_rf_data  <= '0;
            o_rf_src   <= 1'b0;
        end else begin
            // blocked implies IDLE, so starve alone decides the next state
            state      <= starve ? STALL : IDLE;
            o_wb_stall <= starve;
            wait_cnt   <= (blocked && !starve) ? wait_cnt + 8'd1 : 8'd0;
            if (wb_acc && i_wb_reg_num != '0) begin
                o_rf_we   <= 1'b1;
                o_rf_addr <= i_wb_reg_num;
                o_rf_data <= i_wb_w_data;
                o_rf_src  <= 1'b0;
            end else if (dbg_xfer && i_dbg_reg_num != '0) begin
                o_rf_we   <= 1'b1;
                o_rf_addr <= i_dbg_reg_num;
                o_rf_data <= i_dbg_data;
                o_rf_src  <= 1'b1;
            end else begin
                o_rf_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vector table, corner sequences and randomized model comparison.
module tb_rf_write_arbiter;
    localparam int LIM = 4;
    logic        clk = 1'b0;
    logic        i_reset, i_wb_reg_write, i_dbg_valid;
    logic [15:0] i_wb_w_data, i_dbg_data;
    logic [4:0]  i_wb_reg_num, i_dbg_reg_num;
    logic        o_dbg_ready, o_wb_stall, o_rf_we, o_rf_src;
    logic [4:0]  o_rf_addr;
    logic [15:0] o_rf_data;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.NB_DATA(16), .NB_REGISTERS(5), .STARVE_LIMIT(LIM)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_wb_w_data(i_wb_w_data), .i_wb_reg_num(i_wb_reg_num),
        .i_wb_reg_write(i_wb_reg_write), .i_dbg_valid(i_dbg_valid), .i_dbg_reg_num(i_dbg_reg_num),
        .i_dbg_data(i_dbg_data), .o_dbg_ready(o_dbg_ready), .o_wb_stall(o_wb_stall), .o_rf_we(o_rf_we),
        .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data), .o_rf_src(o_rf_src)
    );

    typedef struct {
        logic        rst, wbw, dv, rdy, stall, we, src;
        logic [4:0]  wr, dr, addr;
        logic [15:0] wd, dd, data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input int rst, wbw, wr, wd, dv, dr, dd, rdy, st, we, ad, da, sr);
        vec_t t;
        t.rst = rst[0]; t.wbw = wbw[0]; t.wr = wr[4:0]; t.wd = wd[15:0];
        t.dv = dv[0]; t.dr = dr[4:0]; t.dd = dd[15:0];
        t.rdy = rdy[0]; t.stall = st[0]; t.we = we[0]; t.addr = ad[4:0]; t.data = da[15:0]; t.src = sr[0];
        return t;
    endfunction

    task automatic drive(input logic rst, wbw, input logic [4:0] wr, input logic [15:0] wd,
                         input logic dv, input logic [4:0] dr, input logic [15:0] dd);
        i_reset = rst; i_wb_reg_write = wbw; i_wb_reg_num = wr; i_wb_w_data = wd;
        i_dbg_valid = dv; i_dbg_reg_num = dr; i_dbg_data = dd;
    endtask

    // inputs change 1 after a rising edge; ready is sampled mid-cycle, registered outputs 1 after the next edge
    task automatic apply(input vec_t t, input string tag);
        drive(t.rst, t.wbw, t.wr, t.wd, t.dv, t.dr, t.dd);
        #1;
        chk({tag, ".ready"}, 32'(o_dbg_ready), 32'(t.rdy));
        @(posedge clk); #1;
        chk({tag, ".stall"}, 32'(o_wb_stall), 32'(t.stall));
        chk({tag, ".we"},    32'(o_rf_we),    32'(t.we));
        chk({tag, ".addr"},  32'(o_rf_addr),  32'(t.addr));
        chk({tag, ".data"},  32'(o_rf_data),  32'(t.data));
        chk({tag, ".src"},   32'(o_rf_src),   32'(t.src));
    endtask

    initial begin
        logic        m_stall, m_we, m_src, prev_x, rst, wbw, dv, exp_rdy;
        logic [4:0]  m_addr, wr, dr;
        logic [15:0] m_data, wd, dd;
        int          m_run, n;

        // reset with every request active
        tbl.push_back(v(1, 1, 4, 'h0001, 1, 7, 'h00AB, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 4, 'h0001, 1, 7, 'h00AB, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 4, 'h0001, 0, 0, 0,      0, 0, 1, 4, 'h0001, 0));
        // idle pipeline: debug goes straight through, then outputs hold
        tbl.push_back(v(0, 0, 0, 0, 1, 7, 'h00AB, 1, 0, 1, 7, 'h00AB, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 7, 'h00AB, 1));
        // starvation: four blocked cycles, stall, debug write, then re-presented pipeline write
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 5, 'h1000 + i, 1, 3, 'h1234, 0, int'(i == 3), 1, 5, 'h1000 + i, 0));
        tbl.push_back(v(0, 1, 5, 'h1004, 1, 3, 'h1234, 1, 0, 1, 3, 'h1234, 1));
        tbl.push_back(v(0, 1, 5, 'h1004, 0, 3, 'h1234, 0, 0, 1, 5, 'h1004, 0));
        // register 0 is consumed without a write
        tbl.push_back(v(0, 1, 0, 'hFFFF, 0, 0, 0,      0, 0, 0, 5, 'h1004, 0));
        tbl.push_back(v(0, 0, 0, 0,      1, 0, 'h5555, 1, 0, 0, 5, 'h1004, 0));
        // aborted stall, then a fresh request must again wait the full limit
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 6, 'h2000 + i, 1, 9, 'h9999, 0, int'(i == 3), 1, 6, 'h2000 + i, 0));
        tbl.push_back(v(0, 1, 6, 'h2004, 0, 9, 'h9999, 1, 0, 0, 6, 'h2003, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 6, 'h2004 + i, 1, 9, 'h9999, 0, int'(i == 3), 1, 6, 'h2004 + i, 0));
        tbl.push_back(v(0, 1, 6, 'h2008, 1, 9, 'h9999, 1, 0, 1, 9, 'h9999, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 9, 'h9999, 1));

        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // reset asserted in the stall cycle
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 16'(i), 1, 2, 16'h4242);
            #1 chk("mid.block_ready", 32'(o_dbg_ready), 32'(0));
            @(posedge clk); #1;
        end
        chk("mid.stall_on", 32'(o_wb_stall), 32'(1));
        drive(1, 1, 1, 16'h0004, 1, 2, 16'h4242);
        #1 chk("mid.rst_ready", 32'(o_dbg_ready), 32'(0));
        @(posedge clk); #1;
        chk("mid.stall_off", 32'(o_wb_stall), 32'(0));
        chk("mid.we", 32'(o_rf_we), 32'(0));
        chk("mid.addr", 32'(o_rf_addr), 32'(0));
        n = 0;
        for (int k = 0; k < 10 && o_wb_stall !== 1'b1; k++) begin
            drive(0, 1, 1, 16'(k), 1, 2, 16'h4242);
            @(posedge clk); #1;
            n++;
        end
        chk("mid.wait_after_reset", 32'(n), 32'(LIM));
        apply(v(0, 1, 1, 'h0077, 1, 2, 'h4242, 1, 0, 1, 2, 'h4242, 1), "mid.xfer");

        // randomized run against a cycle-level model of the rules
        m_stall = 0; m_we = 0; m_src = 0; m_addr = 0; m_data = 0; m_run = 0;
        prev_x = 0; dv = 0; dr = 0; dd = 0;
        for (int k = 0; k < 3000; k++) begin
            rst = (k == 0) || ($urandom_range(0, 63) == 0);
            wbw = $urandom_range(0, 3) != 0;
            wr  = 5'($urandom_range(0, 7));
            wd  = 16'($urandom);
            if (!dv || prev_x) begin
                dv = $urandom_range(0, 2) != 0;
                dr = 5'($urandom_range(0, 7));
                dd = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                dv = 0;
            end
            drive(rst, wbw, wr, wd, dv, dr, dd);
            #1;
            exp_rdy = !rst && (m_stall || !wbw);
            chk("rnd.ready", 32'(o_dbg_ready), 32'(exp_rdy));
            prev_x = dv && exp_rdy;
            if (rst) begin
                m_stall = 0; m_we = 0; m_src = 0; m_addr = 0; m_data = 0; m_run = 0;
            end else begin
                if (wbw && !m_stall && wr != 0) begin
                    m_we = 1; m_addr = wr; m_data = wd; m_src = 0;
                end else if (prev_x && dr != 0) begin
                    m_we = 1; m_addr = dr; m_data = dd; m_src = 1;
                end else begin
                    m_we = 0;
                end
                m_run = (dv && !exp_rdy) ? m_run + 1 : 0;
                m_stall = m_run == LIM;
            end
            @(posedge clk); #1;
            chk("rnd.stall", 32'(o_wb_stall), 32'(m_stall));
            chk("rnd.we",    32'(o_rf_we),    32'(m_we));
            chk("rnd.addr",  32'(o_rf_addr),  32'(m_addr));
            chk("rnd.data",  32'(o_rf_data),  32'(m_data));
            chk("rnd.src",   32'(o_rf_src),   32'(m_src));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the single register-file write port between the pipeline write-back stage and the debug unit. The write-back stage has priority. A debug write that has been blocked too long gets a one-cycle pipeline stall, so it cannot starve. Outputs to the register file are registered, and writes to register 0 are discarded.

## Interface

Parameters:
- NB_DATA, 16, data width of register-file writes
- NB_REGISTERS, 5, register index width
- STARVE_LIMIT, 4, number of consecutive blocked cycles a debug request tolerates before a stall is forced; legal range 1..255

Ports:
- i_clk  input  1  single clock; all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_wb_w_data  input  NB_DATA  write data from the write-back stage
- i_wb_reg_num  input  NB_REGISTERS  destination register from the write-back stage
- i_wb_reg_write  input  1  write-back stage requests a write this cycle
- i_dbg_valid  input  1  debug unit presents a write request
- i_dbg_reg_num  input  NB_REGISTERS  debug destination register
- i_dbg_data  input  NB_DATA  debug write data
- o_dbg_ready  output  1  debug request is accepted this cycle (combinational)
- o_wb_stall  output  1  freeze request to the pipeline (registered)
- o_rf_we  output  1  register-file write enable
- o_rf_addr  output  NB_REGISTERS  register-file write address
- o_rf_data  output  NB_DATA  register-file write data
- o_rf_src  output  1  source of the current write: 0 = pipeline, 1 = debug

## Operation

States:
- IDLE: o_wb_stall = 0.
- STALL: o_wb_stall = 1. Always lasts exactly one cycle.

Acceptance rules:
- A pipeline write is accepted when i_wb_reg_write = 1 and o_wb_stall = 0.
- While o_wb_stall = 1, i_wb_reg_write is ignored. The frozen pipeline re-presents the same write after the stall.
- o_dbg_ready = !i_reset & (o_wb_stall | !i_wb_reg_write).
- A debug transfer occurs when i_dbg_valid & o_dbg_ready.
- A debug request is "blocked" when i_dbg_valid = 1 and o_dbg_ready = 0.

Wait counter (wait_cnt, 8-bit):
- Increments on each blocked cycle.
- Clears to 0 on a debug transfer, when i_dbg_valid = 0, and in STALL.

Transitions:
- IDLE to STALL when the request is blocked and wait_cnt == STARVE_LIMIT-1. A debug request is therefore blocked for exactly STARVE_LIMIT cycles.
- STALL to IDLE unconditionally.
- If i_dbg_valid drops while in STALL, the stall cycle still occurs and no write is issued.

Write port update, each cycle, priority in this order:
1. Accepted pipeline write with i_wb_reg_num != 0: o_rf_we = 1, address and data from the pipeline, o_rf_src = 0.
2. Debug transfer with i_dbg_reg_num != 0: o_rf_we = 1, address and data from the debug unit, o_rf_src = 1.
3. Otherwise: o_rf_we = 0; o_rf_addr, o_rf_data and o_rf_src hold their previous values.

Register 0 handling:
- An accepted write to register 0 counts as consumed: the handshake completes and the counter clears.
- No register-file write is issued for it.

Reset:
- While i_reset = 1: state = IDLE, wait_cnt = 0, and every output is 0 (o_rf_we, o_rf_addr, o_rf_data, o_rf_src, o_wb_stall, o_dbg_ready). No transfer is accepted.
- Reset asserted during STALL aborts the stall. Operation resumes in IDLE on the first cycle after reset deasserts.

## Timing

- Latency: a write accepted in cycle N appears on o_rf_* in cycle N+1, with o_rf_we high for one cycle only.
- o_dbg_ready is combinational from i_wb_reg_write, o_wb_stall and i_reset. The debug unit must not make i_dbg_valid depend on o_dbg_ready.
- Debug valid/ready rule: once i_dbg_valid is asserted, i_dbg_reg_num and i_dbg_data stay stable until the transfer completes.
- Worst-case debug wait: the request is blocked for STARVE_LIMIT cycles, then transfers in the STALL cycle. The write lands STARVE_LIMIT+1 cycles after the first blocked cycle.
- Back-to-back debug writes under continuous pipeline writes: each one pays the full STARVE_LIMIT wait, because the counter restarts after STALL.
- With STARVE_LIMIT = 1: STALL follows the first blocked cycle.

## Test plan

- Reset: hold i_reset for 2 cycles with all requests active -> every output is 0 and no write occurs. After release, the pipeline write {reg 4, 0x0001} gives o_rf_we = 1, addr 4, data 0x0001, src 0 one cycle later.
- Idle pipeline: debug {reg 7, 0x00AB} with i_wb_reg_write = 0 -> o_dbg_ready = 1 in the same cycle. Next cycle: o_rf_we = 1, addr 7, data 0x00AB, src 1.
- Conflict and starvation (STARVE_LIMIT = 4): pipeline writes every cycle; debug {reg 3, 0x1234} asserted at cycle 0.
  - Required: ready = 0 in cycles 0-3; o_wb_stall = 1 and ready = 1 in cycle 4.
  - The debug write appears in cycle 5.
  - The pipeline write presented in cycle 4 is not issued; its re-presentation in cycle 5 is issued in cycle 6.
- Register 0: pipeline write {reg 0, 0xFFFF}, then debug write {reg 0, 0x5555} -> o_rf_we stays 0 for both. The debug handshake still completes (ready = 1 with valid).
- Aborted stall: debug request blocked 4 cycles, then i_dbg_valid drops in the STALL cycle -> o_wb_stall is high for one cycle, no write issued, state returns to IDLE, wait_cnt = 0.
- Reset mid-stall: assert i_reset in the STALL cycle -> o_wb_stall = 0 the next cycle. After release, a fresh blocked request again waits the full 4 cycles.
